// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int REG_DATA_W = 32;
    localparam int MEM_MASK_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/arb_grant.sv
// Combinational winner select between the fetch unit and the load/store unit.
// With MEM_ARB_RR_EN defined, a tie goes to the master that did not win last;
// otherwise the LSU always wins a tie.
module arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic any_valid,
    output logic grant
);

    // Pick the winner from the current request lines
    always_comb begin
        any_valid = ifu_valid | lsu_valid;
        grant     = GRANT_IFU;
`ifdef MEM_ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            grant = ~last_grant;
        end else if (lsu_valid) begin
            grant = GRANT_LSU;
        end
`else
        if (lsu_valid) begin
            grant = GRANT_LSU;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single data-memory port between the IFU and the LSU.
// One transaction is in flight at a time: IDLE accepts, REQ presents the
// registered request to memory, RESP forwards the response to the owner.
// Define MEM_ARB_RR_EN for round-robin tie breaking instead of LSU priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int MASK_W = MEM_MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid_i,
    output logic              ifu_req_ready_o,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_resp_valid_o,
    input  logic              ifu_resp_ready_i,
    output logic [DATA_W-1:0] ifu_rdata_o,
    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [MASK_W-1:0] lsu_wmask_i,
    output logic              lsu_resp_valid_o,
    input  logic              lsu_resp_ready_i,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              grant_o,
    output logic              busy_o
);

    arb_state_t        state_q;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              win_grant;
    logic              any_valid;
    logic              in_idle;
    logic              in_resp;
    logic              owner_resp_ready;
`ifdef MEM_ARB_RR_EN
    logic              last_grant_q;
`endif

    arb_grant u_arb_grant (
        .ifu_valid  (ifu_req_valid_i),
        .lsu_valid  (lsu_req_valid_i),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .any_valid  (any_valid),
        .grant      (win_grant)
    );

    assign in_idle          = (state_q == ARB_IDLE);
    assign in_resp          = (state_q == ARB_RESP);
    assign owner_resp_ready = (grant_q == GRANT_LSU) ? lsu_resp_ready_i : ifu_resp_ready_i;

    // The reset term keeps the accept strobes low while reset is held, even
    // though the state register already reads IDLE during reset.
    assign ifu_req_ready_o  = rst & in_idle & ifu_req_valid_i & (win_grant == GRANT_IFU);
    assign lsu_req_ready_o  = rst & in_idle & lsu_req_valid_i & (win_grant == GRANT_LSU);

    assign mem_req_valid_o  = (state_q == ARB_REQ);
    assign mem_resp_ready_o = in_resp & owner_resp_ready;
    assign ifu_resp_valid_o = in_resp & (grant_q == GRANT_IFU) & mem_resp_valid_i;
    assign lsu_resp_valid_o = in_resp & (grant_q == GRANT_LSU) & mem_resp_valid_i;
    assign ifu_rdata_o      = mem_rdata_i;
    assign lsu_rdata_o      = mem_rdata_i;

    assign mem_we_o         = we_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wmask_o      = wmask_q;
    assign grant_o          = grant_q;
    assign busy_o           = ~in_idle;

    // Transaction FSM: capture on accept, hold for memory, forward response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GRANT_IFU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= GRANT_IFU;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_valid) begin
                        grant_q <= win_grant;
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= win_grant;
`endif
                        if (win_grant == GRANT_LSU) begin
                            we_q    <= lsu_we_i;
                            addr_q  <= lsu_addr_i;
                            wdata_q <= lsu_wdata_i;
                            wmask_q <= lsu_wmask_i;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= ifu_addr_i;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                        state_q <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready_i) begin
                        state_q <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_resp_valid_i && owner_resp_ready) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected memory
// requests and master responses; a monitor pops and compares on handshakes.
// Expected grant order adapts to MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid_i;
    logic        ifu_req_ready_o;
    logic [31:0] ifu_addr_i;
    logic        ifu_resp_valid_o;
    logic        ifu_resp_ready_i;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [7:0]  lsu_wmask_i;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_ready_i;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_rdata_i;
    logic        grant_o;
    logic        busy_o;

    typedef struct {
        logic        g;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } mem_exp_t;

    typedef struct {
        logic        g;
        logic [31:0] rdata;
    } resp_exp_t;

    mem_exp_t  exp_mem_q[$];
    resp_exp_t exp_resp_q[$];
    int        checks = 0;
    int        failures = 0;
    int        req_stall_next = 0;
    logic      exp_g[4];

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_valid_i  (ifu_req_valid_i),
        .ifu_req_ready_o  (ifu_req_ready_o),
        .ifu_addr_i       (ifu_addr_i),
        .ifu_resp_valid_o (ifu_resp_valid_o),
        .ifu_resp_ready_i (ifu_resp_ready_i),
        .ifu_rdata_o      (ifu_rdata_o),
        .lsu_req_valid_i  (lsu_req_valid_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_we_i         (lsu_we_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_wmask_i      (lsu_wmask_i),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_ready_i (lsu_resp_ready_i),
        .lsu_rdata_o      (lsu_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_rdata_i      (mem_rdata_i),
        .grant_o          (grant_o),
        .busy_o           (busy_o)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return ~a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushMem(input logic g, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [7:0] wmask);
        mem_exp_t e;
        e.g = g; e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        exp_mem_q.push_back(e);
    endtask

    task automatic pushResp(input logic g, input logic [31:0] rdata);
        resp_exp_t e;
        e.g = g; e.rdata = rdata;
        exp_resp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive requests on either master and hold each until it is accepted
    task automatic applyStimulus(input logic do_ifu, input logic [31:0] i_addr,
                                 input logic do_lsu, input logic we, input logic [31:0] l_addr,
                                 input logic [31:0] wdata, input logic [7:0] wmask);
        logic ia, la;
        int   n;
        ifu_req_valid_i = do_ifu;
        ifu_addr_i      = i_addr;
        lsu_req_valid_i = do_lsu;
        lsu_we_i        = we;
        lsu_addr_i      = l_addr;
        lsu_wdata_i     = wdata;
        lsu_wmask_i     = wmask;
        n = 0;
        while ((ifu_req_valid_i || lsu_req_valid_i) && n < 100) begin
            #5;
            ia = ifu_req_valid_i & ifu_req_ready_o;
            la = lsu_req_valid_i & lsu_req_ready_o;
            nextCycle();
            if (ia) ifu_req_valid_i = 1'b0;
            if (la) lsu_req_valid_i = 1'b0;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 100 cycles");
            ifu_req_valid_i = 1'b0;
            lsu_req_valid_i = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy_o || exp_resp_q.size() != 0) && n < 200) begin
            nextCycle();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: got busy=%0d expected idle within 200 cycles", busy_o);
        end
    endtask

    // Memory model: optional request stall, one-cycle response, honours resp ready
    int          m_phase = 0;
    int          m_cnt = 0;
    logic        m_seen = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'h0;
    initial begin
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_phase = 0; m_seen = 1'b0; m_cnt = 0;
                mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = 32'h0;
            end else begin
                case (m_phase)
                    0: if (mem_req_valid_o) begin
                        if (!m_seen) begin
                            m_cnt  = req_stall_next;
                            m_seen = 1'b1;
                        end
                        if (m_cnt > 0) begin
                            m_cnt--;
                            mem_req_ready_i = 1'b0;
                        end else begin
                            mem_req_ready_i = 1'b1;
                            m_addr  = mem_addr_o;
                            m_we    = mem_we_o;
                            m_seen  = 1'b0;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        mem_req_ready_i  = 1'b0;
                        mem_resp_valid_i = 1'b1;
                        mem_rdata_i      = m_we ? 32'h0 : mem_word(m_addr);
                        m_phase          = mem_resp_ready_o ? 3 : 2;
                    end
                    2: if (mem_resp_ready_o) m_phase = 3;
                    default: begin
                        mem_resp_valid_i = 1'b0;
                        mem_rdata_i      = 32'h0;
                        m_phase          = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: compare every memory request and master response handshake
    initial begin
        mem_exp_t  em;
        resp_exp_t er;
        forever begin
            @(posedge clk);
            #8;
            if (rst) begin
                if (mem_req_valid_o && mem_req_ready_i) begin
                    if (exp_mem_q.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL mem_req_unexpected: got addr 0x%08h expected no request", mem_addr_o);
                    end else begin
                        em = exp_mem_q.pop_front();
                        checkOutput("mem_grant", 32'(grant_o), 32'(em.g));
                        checkOutput("mem_we", 32'(mem_we_o), 32'(em.we));
                        checkOutput("mem_addr", mem_addr_o, em.addr);
                        checkOutput("mem_wdata", mem_wdata_o, em.wdata);
                        checkOutput("mem_wmask", 32'(mem_wmask_o), 32'(em.wmask));
                    end
                end
                if (ifu_resp_valid_o && ifu_resp_ready_i) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL ifu_resp_unexpected: got rdata 0x%08h expected no response", ifu_rdata_o);
                    end else begin
                        er = exp_resp_q.pop_front();
                        checkOutput("resp_owner_ifu", 32'd0, 32'(er.g));
                        checkOutput("ifu_rdata", ifu_rdata_o, er.rdata);
                    end
                end
                if (lsu_resp_valid_o && lsu_resp_ready_i) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL lsu_resp_unexpected: got rdata 0x%08h expected no response", lsu_rdata_o);
                    end else begin
                        er = exp_resp_q.pop_front();
                        checkOutput("resp_owner_lsu", 32'd1, 32'(er.g));
                        checkOutput("lsu_rdata", lsu_rdata_o, er.rdata);
                    end
                end
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        logic got;
        int   n;
        int   cyc;

`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b0;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0000; ifu_resp_ready_i = 1'b1;
        lsu_req_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = 32'h0;
        lsu_wdata_i = 32'h0; lsu_wmask_i = 8'h0; lsu_resp_ready_i = 1'b1;
        repeat (3) nextCycle();

        // Reset state, with an IFU request already pending
        checkOutput("rst_ifu_req_ready", 32'(ifu_req_ready_o), 32'd0);
        checkOutput("rst_lsu_req_ready", 32'(lsu_req_ready_o), 32'd0);
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
        checkOutput("rst_mem_resp_ready", 32'(mem_resp_ready_o), 32'd0);
        checkOutput("rst_ifu_resp_valid", 32'(ifu_resp_valid_o), 32'd0);
        checkOutput("rst_lsu_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_grant", 32'(grant_o), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we_o), 32'd0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'h0);
        checkOutput("rst_mem_wmask", 32'(mem_wmask_o), 32'd0);

        // First fetch right after reset release: 3-cycle transaction
        pushMem(1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
        pushResp(1'b0, 32'h0000_0413);
        rst = 1'b1;
        #5 checkOutput("c0_ifu_req_ready", 32'(ifu_req_ready_o), 32'd1);
        nextCycle();
        ifu_req_valid_i = 1'b0;
        #5 checkOutput("c1_mem_req_valid", 32'(mem_req_valid_o), 32'd1);
        checkOutput("c1_mem_we", 32'(mem_we_o), 32'd0);
        nextCycle();
        #5 checkOutput("c2_ifu_resp_valid", 32'(ifu_resp_valid_o), 32'd1);
        checkOutput("c2_ifu_rdata", ifu_rdata_o, 32'h0000_0413);
        checkOutput("c2_lsu_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        nextCycle();
        #5 checkOutput("c3_busy", 32'(busy_o), 32'd0);
        nextCycle();

        // Simultaneous requests: LSU store first, then IFU read
        pushMem(1'b1, 1'b1, 32'h8000_0101, 32'hAABB_CCDD, 8'h02);
        pushResp(1'b1, 32'h0);
        pushMem(1'b0, 1'b0, 32'h8000_0004, 32'h0, 8'h00);
        pushResp(1'b0, 32'h7FFF_FFFB);
        applyStimulus(1'b1, 32'h8000_0004, 1'b1, 1'b1, 32'h8000_0101, 32'hAABB_CCDD, 8'h02);
        waitIdle();

        // Both masters held valid across four transactions
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i]) begin
                pushMem(1'b1, 1'b0, 32'h8000_0200, 32'h1111_2222, 8'hFF);
                pushResp(1'b1, 32'h7FFF_FDFF);
            end else begin
                pushMem(1'b0, 1'b0, 32'h8000_0008, 32'h0, 8'h00);
                pushResp(1'b0, 32'h7FFF_FFF7);
            end
        end
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0008;
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0200;
        lsu_wdata_i = 32'h1111_2222; lsu_wmask_i = 8'hFF;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 200) begin
            #5;
            if (ifu_req_ready_o || lsu_req_ready_o) begin
                checkOutput("both_valid_winner", 32'(lsu_req_ready_o), 32'(exp_g[n]));
                n++;
            end
            nextCycle();
            cyc++;
        end
        ifu_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b0;
        checkOutput("both_valid_accepts", 32'(n), 32'd4);
        waitIdle();

        // Memory stalls the request; LSU stalls the response
        req_stall_next   = 5;
        lsu_resp_ready_i = 1'b0;
        pushMem(1'b1, 1'b1, 32'h8000_0300, 32'h0BAD_F00D, 8'hF0);
        pushResp(1'b1, 32'h0);
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0300;
        lsu_wdata_i = 32'h0BAD_F00D; lsu_wmask_i = 8'hF0;
        #5 checkOutput("stall_lsu_req_ready", 32'(lsu_req_ready_o), 32'd1);
        nextCycle();
        lsu_req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #5;
            checkOutput("stall_mem_req_valid", 32'(mem_req_valid_o), 32'd1);
            checkOutput("stall_mem_addr", mem_addr_o, 32'h8000_0300);
            checkOutput("stall_mem_wdata", mem_wdata_o, 32'h0BAD_F00D);
            nextCycle();
        end
        req_stall_next = 0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            #5;
            got = lsu_resp_valid_o;
            if (!got) begin
                nextCycle();
                cyc++;
            end
        end
        checkOutput("stall_resp_seen", 32'(got), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                nextCycle();
                #5;
            end
            checkOutput("hold_mem_resp_ready", 32'(mem_resp_ready_o), 32'd0);
            checkOutput("hold_busy", 32'(busy_o), 32'd1);
            checkOutput("hold_lsu_resp_valid", 32'(lsu_resp_valid_o), 32'd1);
        end
        nextCycle();
        lsu_resp_ready_i = 1'b1;
        #5 checkOutput("release_mem_resp_ready", 32'(mem_resp_ready_o), 32'd1);
        nextCycle();
        waitIdle();

        // Reset asserted while a request waits on memory
        req_stall_next  = 10;
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0010;
        lsu_wdata_i = 32'h1234_5678; lsu_wmask_i = 8'h0F;
        #5 checkOutput("abort_lsu_accept", 32'(lsu_req_ready_o), 32'd1);
        nextCycle();
        lsu_req_valid_i = 1'b0;
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_grant", 32'(grant_o), 32'd0);
        checkOutput("abort_mem_we", 32'(mem_we_o), 32'd0);
        checkOutput("abort_mem_addr", mem_addr_o, 32'h0);
        checkOutput("abort_mem_wdata", mem_wdata_o, 32'h0);
        checkOutput("abort_mem_wmask", 32'(mem_wmask_o), 32'd0);
        nextCycle();
        nextCycle();
        req_stall_next = 0;
        rst = 1'b1;
        pushMem(1'b0, 1'b0, 32'h8000_0014, 32'h0, 8'h00);
        pushResp(1'b0, 32'h7FFF_FFEB);
        applyStimulus(1'b1, 32'h8000_0014, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
        waitIdle();
        repeat (3) nextCycle();

        checkOutput("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
        checkOutput("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
